// File: rtl/redirect_ctrl_if.sv
// Redirect/flush bus between redirect_ctrl and the IDU/EXU/LSU/I-cache/IFU side.
// master: the redirect controller; slave: the pipeline units around it.
interface redirect_ctrl_if;
    logic        idu_jump_flush;
    logic [31:0] idu_jump_dnpc;
    logic        exu_trap_valid;
    logic [31:0] exu_trap_dnpc;
    logic        exu_fencei_valid;
    logic [31:0] exu_fencei_pc;
    logic        lsu_idle;
    logic        icache_flush_ack;
    logic        icache_flush_req;
    logic        ifu_redirect;
    logic [31:0] ifu_redirect_pc;
    logic        idu_flush;
    logic        busy;

    modport master (
        input  idu_jump_flush, idu_jump_dnpc,
        input  exu_trap_valid, exu_trap_dnpc,
        input  exu_fencei_valid, exu_fencei_pc,
        input  lsu_idle, icache_flush_ack,
        output icache_flush_req, ifu_redirect, ifu_redirect_pc, idu_flush, busy
    );

    modport slave (
        output idu_jump_flush, idu_jump_dnpc,
        output exu_trap_valid, exu_trap_dnpc,
        output exu_fencei_valid, exu_fencei_pc,
        output lsu_idle, icache_flush_ack,
        input  icache_flush_req, ifu_redirect, ifu_redirect_pc, idu_flush, busy
    );
endinterface

// File: rtl/redirect_ctrl.sv
// Central PC-redirect and flush sequencer: arbitrates trap/mret, fence.i and
// branch-mispredict redirects, runs the fence.i drain/I-cache-flush/resume
// sequence, and holds fetch after reset before releasing it at RESET_PC.
module redirect_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h3000_0000,
    parameter int unsigned BOOT_HOLD = 4
) (
    input logic            clock,
    input logic            reset,
    redirect_ctrl_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(BOOT_HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BOOT_HOLD - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_DRAIN,
        S_IFLUSH,
        S_RESUME
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      saved_pc_q, saved_pc_d;
    logic             req_q, req_d;

    logic [31:0]      redirect_pc;

    // Next-state, boot counter, resume PC and I-cache request computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        saved_pc_d = saved_pc_q;
        req_d      = req_q;
        case (state_q)
            S_BOOT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d    = S_RESUME;
                    saved_pc_d = RESET_PC;
                end
            end
            S_IDLE: begin
                // trap outranks fence.i; a jump never leaves IDLE
                if (!bus.exu_trap_valid && bus.exu_fencei_valid) begin
                    state_d    = S_DRAIN;
                    saved_pc_d = bus.exu_fencei_pc + 32'd4;
                end
            end
            S_DRAIN: begin
                if (bus.lsu_idle) begin
                    state_d = S_IFLUSH;
                    req_d   = 1'b1;
                end
            end
            S_IFLUSH: begin
                if (bus.icache_flush_ack) begin
                    state_d = S_RESUME;
                    req_d   = 1'b0;
                end
            end
            S_RESUME: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_BOOT;
                cnt_d   = CNT_INIT;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset into BOOT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_BOOT;
            cnt_q      <= CNT_INIT;
            saved_pc_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            saved_pc_q <= saved_pc_d;
            req_q      <= req_d;
        end
    end

    // Per-state combinational outputs; IDLE arbitration is same-cycle.
    always_comb begin
        bus.ifu_redirect = 1'b0;
        bus.idu_flush    = 1'b1;
        bus.busy         = 1'b1;
        redirect_pc      = saved_pc_q;
        case (state_q)
            S_IDLE: begin
                bus.busy      = 1'b0;
                bus.idu_flush = 1'b0;
                if (bus.exu_trap_valid) begin
                    bus.ifu_redirect = 1'b1;
                    bus.idu_flush    = 1'b1;
                    redirect_pc      = bus.exu_trap_dnpc;
                end else if (bus.exu_fencei_valid) begin
                    bus.idu_flush = 1'b1;
                end else if (bus.idu_jump_flush) begin
                    bus.ifu_redirect = 1'b1;
                    redirect_pc      = bus.idu_jump_dnpc;
                end
            end
            S_RESUME: begin
                bus.ifu_redirect = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.ifu_redirect_pc  = {redirect_pc[31:1], 1'b0};
    assign bus.icache_flush_req = req_q;

endmodule
